// File: rtl/cpu_sequencer.sv
// E0C6S46 instruction sequencer: fetches ROM words into the instruction
// register, steps decode's microcode entry, and schedules HALT/IRQ entry.
// Ports:
//   clk, reset_n, clk_en        clock, async active-low reset, cycle enable
//   rom_data                    ROM word, captured one enabled cycle after fetch
//   dec_microcode_addr/..._len  decode results for the current opcode
//   dec_skip_pc_inc             suppress PC advance on the last cycle
//   irq_pending, irq_enable     interrupt request and CPU I flag
//   halt_req                    HALT/SLP request from microcode
//   fetch_strobe, opcode        ROM read strobe and instruction register
//   microcode_addr, micro_step  current microcode entry and step
//   micro_valid, pc_increment   step active, PC advance
//   instr_done, irq_ack, halted sequence end, IRQ entry, halt status
module cpu_sequencer #(
    parameter logic [6:0] IRQ_MICROCODE_ADDR  = 7'd98,
    parameter logic [6:0] PSET_MICROCODE_ADDR = 7'd36
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic [11:0] rom_data,
    input  logic [6:0]  dec_microcode_addr,
    input  logic [1:0]  dec_cycle_length,
    input  logic        dec_skip_pc_inc,
    input  logic        irq_pending,
    input  logic        irq_enable,
    input  logic        halt_req,
    output logic        fetch_strobe,
    output logic [11:0] opcode,
    output logic [6:0]  microcode_addr,
    output logic [3:0]  micro_step,
    output logic        micro_valid,
    output logic        pc_increment,
    output logic        instr_done,
    output logic        irq_ack,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH_EXEC = 2'd0,
        IRQ        = 2'd1,
        HALT       = 2'd2
    } state_t;

    localparam logic [1:0] CYCLE5  = 2'd0;
    localparam logic [1:0] CYCLE7  = 2'd1;
    localparam logic [1:0] CYCLE12 = 2'd2;

    state_t      state, state_nx;
    logic [3:0]  step, step_nx;
    logic [1:0]  len;
    logic        skip;
    logic [6:0]  maddr;
    logic        halt_sticky;
    logic [3:0]  last_step;
    logic        irq_take;
    logic        irq_block;

    // Unused length encodings fall back to the 5-cycle form.
    always_comb begin
        case (len)
            CYCLE7:  last_step = 4'd6;
            CYCLE12: last_step = 4'd11;
            default: last_step = 4'd4;
        endcase
    end

    assign irq_take  = irq_pending & irq_enable;
    // The instruction just finished is PSET: its boundary must not take an IRQ.
    assign irq_block = (maddr == PSET_MICROCODE_ADDR);

    always_comb begin
        state_nx       = state;
        step_nx        = step;
        fetch_strobe   = 1'b0;
        microcode_addr = maddr;
        micro_step     = 4'd0;
        micro_valid    = 1'b0;
        pc_increment   = 1'b0;
        instr_done     = 1'b0;
        irq_ack        = 1'b0;
        halted         = 1'b0;
        case (state)
            FETCH_EXEC: begin
                fetch_strobe = (step == 4'd0);
                step_nx      = step + 4'd1;
                if (step >= 4'd2) begin
                    micro_valid = 1'b1;
                    micro_step  = step - 4'd2;
                    // Decode result is not registered yet on the first microstep.
                    if (step == 4'd2) begin
                        microcode_addr = dec_microcode_addr;
                    end
                    // last_step >= 4, so this only fires after len is loaded.
                    if (step == last_step) begin
                        instr_done   = 1'b1;
                        pc_increment = !skip;
                        step_nx      = 4'd0;
                        if (halt_sticky || halt_req) begin
                            state_nx = HALT;
                        end else if (irq_take && !irq_block) begin
                            state_nx = IRQ;
                        end
                    end
                end
            end
            IRQ: begin
                micro_valid    = 1'b1;
                microcode_addr = IRQ_MICROCODE_ADDR;
                micro_step     = step;
                irq_ack        = (step == 4'd0);
                step_nx        = step + 4'd1;
                if (step == 4'd11) begin
                    instr_done = 1'b1;
                    step_nx    = 4'd0;
                    state_nx   = FETCH_EXEC;
                end
            end
            HALT: begin
                halted  = 1'b1;
                step_nx = 4'd0;
                if (irq_take) begin
                    state_nx = IRQ;
                end
            end
            default: begin
                state_nx = FETCH_EXEC;
                step_nx  = 4'd0;
            end
        endcase
        // Strobes are held low for as long as reset is asserted.
        if (!reset_n) begin
            fetch_strobe = 1'b0;
            micro_valid  = 1'b0;
            pc_increment = 1'b0;
            instr_done   = 1'b0;
            irq_ack      = 1'b0;
            halted       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH_EXEC;
            step        <= 4'd0;
            opcode      <= 12'hFFB;
            len         <= CYCLE5;
            skip        <= 1'b0;
            maddr       <= 7'd0;
            halt_sticky <= 1'b0;
        end else if (clk_en) begin
            state <= state_nx;
            step  <= step_nx;
            if (state == FETCH_EXEC && step == 4'd1) begin
                opcode <= rom_data;
            end
            if (state == FETCH_EXEC && step == 4'd2) begin
                len   <= dec_cycle_length;
                skip  <= dec_skip_pc_inc;
                maddr <= dec_microcode_addr;
            end
            if (state_nx == HALT && state != HALT) begin
                halt_sticky <= 1'b0;
            end else if (micro_valid && halt_req) begin
                halt_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed scenarios plus random instruction
// streams checked cycle by cycle against an instruction-level model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [11:0] rom_data;
    logic [6:0]  dec_microcode_addr;
    logic [1:0]  dec_cycle_length;
    logic        dec_skip_pc_inc;
    logic        irq_pending;
    logic        irq_enable;
    logic        halt_req;
    logic        fetch_strobe;
    logic [11:0] opcode;
    logic [6:0]  microcode_addr;
    logic [3:0]  micro_step;
    logic        micro_valid;
    logic        pc_increment;
    logic        instr_done;
    logic        irq_ack;
    logic        halted;

    cpu_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clk_en            (clk_en),
        .rom_data          (rom_data),
        .dec_microcode_addr(dec_microcode_addr),
        .dec_cycle_length  (dec_cycle_length),
        .dec_skip_pc_inc   (dec_skip_pc_inc),
        .irq_pending       (irq_pending),
        .irq_enable        (irq_enable),
        .halt_req          (halt_req),
        .fetch_strobe      (fetch_strobe),
        .opcode            (opcode),
        .microcode_addr    (microcode_addr),
        .micro_step        (micro_step),
        .micro_valid       (micro_valid),
        .pc_increment      (pc_increment),
        .instr_done        (instr_done),
        .irq_ack           (irq_ack),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic        e_fs, e_mv, e_pi, e_dn, e_ak, e_hl;
    logic [6:0]  e_ad;
    logic [3:0]  e_st;
    logic [11:0] e_op;
    bit          stall_en = 0;
    int          halt_idle = 0;
    int          irq_rst_at = -1;
    int          icnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Address and step only matter while a microstep is active.
    function automatic logic [31:0] pk(input logic fs, mv, pi, dn, ak, hl,
                                       input logic [6:0] ad,
                                       input logic [3:0] st);
        return {15'd0, fs, mv, pi, dn, ak, hl,
                mv ? ad : 7'd0, mv ? st : 4'd0};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pk(fetch_strobe, micro_valid, pc_increment, instr_done,
                  irq_ack, halted, microcode_addr, micro_step);
    endfunction

    task automatic set_exp(input logic fs, mv, pi, dn, ak, hl,
                           input logic [6:0] ad, input logic [3:0] st);
        e_fs = fs; e_mv = mv; e_pi = pi; e_dn = dn;
        e_ak = ak; e_hl = hl; e_ad = ad; e_st = st;
    endtask

    // One enabled CPU cycle; optionally inserts a disabled cycle with
    // scrambled inputs that must leave everything frozen.
    task automatic cyc(input string tag);
        logic [11:0] sr;
        logic        sh, sp;
        @(negedge clk);
        chk(tag, dut_vec(), pk(e_fs, e_mv, e_pi, e_dn, e_ak, e_hl, e_ad, e_st));
        chk({tag, ".op"}, {20'd0, opcode}, {20'd0, e_op});
        if (stall_en && $urandom_range(0, 2) == 0) begin
            sr = rom_data; sh = halt_req; sp = irq_pending;
            clk_en = 1'b0;
            rom_data = 12'($urandom);
            halt_req = 1'($urandom);
            irq_pending = 1'($urandom);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".hold"}, dut_vec(),
                pk(e_fs, e_mv, e_pi, e_dn, e_ak, e_hl, e_ad, e_st));
            chk({tag, ".hold_op"}, {20'd0, opcode}, {20'd0, e_op});
            rom_data = sr; halt_req = sh; irq_pending = sp;
            clk_en = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, ".out"}, dut_vec(), 32'd0);
        chk({tag, ".op"}, {20'd0, opcode}, 32'h0000_0FFB);
        @(posedge clk); #1;
        chk({tag, ".hold"}, dut_vec(), 32'd0);
        reset_n = 1'b1;
        e_op = 12'hFFB;
    endtask

    task automatic do_irq();
        for (int s = 0; s < 12; s++) begin
            irq_pending = 1'b0;
            halt_req = 1'b0;
            if (s == irq_rst_at) begin
                irq_rst_at = -1;
                apply_reset("rst_mid_irq");
                return;
            end
            set_exp(0, 1, 0, s == 11, s == 0, 0, 7'd98, 4'(s));
            cyc($sformatf("irq%0d.s%0d", icnt, s));
        end
    endtask

    task automatic do_halt(input int idle);
        for (int k = 0; k <= idle; k++) begin
            halt_req = 1'($urandom);
            if (k < idle) begin
                irq_pending = 1'($urandom);
                irq_enable = 1'b0;
            end else begin
                irq_pending = 1'b1;
                irq_enable = 1'b1;
            end
            set_exp(0, 0, 0, 0, 0, 1, 7'd0, 4'd0);
            cyc($sformatf("halt%0d.k%0d", icnt, k));
        end
        do_irq();
    endtask

    // Instruction-level model: N cycles per length class, microsteps from
    // cycle 2, then the boundary picks HALT, IRQ or the next fetch.
    task automatic do_instr(input logic [11:0] w, input logic [1:0] lc,
                            input logic sk, input logic [6:0] ma,
                            input int halt_at, input int irq_st,
                            input bit rnd);
        int n;
        bit hp;
        n = (lc == 2'd1) ? 7 : (lc == 2'd2) ? 12 : 5;
        hp = 0;
        icnt++;
        for (int s = 0; s < n; s++) begin
            rom_data = (s == 1) ? w : 12'($urandom);
            dec_cycle_length = (s == 2) ? lc : 2'($urandom);
            dec_skip_pc_inc = (s == 2) ? sk : 1'($urandom);
            dec_microcode_addr = (s == 2) ? ma : 7'($urandom);
            if (s >= 2) halt_req = (s - 2 == halt_at);
            else halt_req = rnd ? 1'($urandom) : 1'b0;
            if (rnd) begin
                irq_pending = ($urandom_range(0, 5) == 0);
                irq_enable = 1'($urandom);
            end else if (s == irq_st) begin
                irq_pending = 1'b1;
                irq_enable = 1'b1;
            end
            if (s >= 2 && halt_req) hp = 1;
            set_exp(s == 0, s >= 2, (s == n - 1) && !sk, s == n - 1,
                    0, 0, ma, 4'(s - 2));
            cyc($sformatf("i%0d.s%0d", icnt, s));
            if (s == 1) e_op = w;
        end
        if (hp) do_halt(halt_idle);
        else if (irq_pending && irq_enable && ma != 7'd36) do_irq();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lc, n;
        int ha;
        reset_n = 1'b0;
        clk_en = 1'b1;
        rom_data = 12'd0;
        dec_microcode_addr = 7'd0;
        dec_cycle_length = 2'd0;
        dec_skip_pc_inc = 1'b0;
        irq_pending = 1'b0;
        irq_enable = 1'b0;
        halt_req = 1'b0;
        e_op = 12'hFFB;
        @(posedge clk); #1;
        apply_reset("reset");

        // JP, then RETD with PC skip
        do_instr(12'h0A5, 2'd0, 1'b0, 7'd5, -1, -1, 0);
        do_instr(12'h1FF, 2'd2, 1'b1, 7'd1, -1, -1, 0);
        // IRQ raised mid NOP7 waits for the boundary
        do_instr(12'hFFF, 2'd1, 1'b0, 7'd2, -1, 2, 0);
        // PSET blocks the IRQ for one boundary
        do_instr(12'hE40, 2'd0, 1'b0, 7'd36, -1, 0, 0);
        do_instr(12'hFFB, 2'd0, 1'b0, 7'd0, -1, -1, 0);
        // HALT held for 100 cycles
        halt_idle = 100;
        do_instr(12'hFF8, 2'd0, 1'b0, 7'd3, 2, -1, 0);
        // HALT with IRQ already pending exits at once
        halt_idle = 0;
        irq_enable = 1'b1;
        do_instr(12'hFF8, 2'd0, 1'b0, 7'd3, 2, 0, 0);
        // Unused length code behaves as CYCLE5
        do_instr(12'h3C1, 2'd3, 1'b0, 7'd9, -1, -1, 0);
        // Clock-enable gaps, then reset in the middle of an IRQ
        stall_en = 1;
        do_instr(12'hFFF, 2'd1, 1'b0, 7'd2, -1, -1, 0);
        irq_rst_at = 5;
        do_instr(12'hFFF, 2'd1, 1'b1, 7'd2, -1, 0, 0);
        irq_rst_at = -1;
        do_instr(12'h0A5, 2'd0, 1'b0, 7'd5, -1, -1, 0);

        for (int i = 0; i < 60; i++) begin
            stall_en = 1'($urandom);
            lc = $urandom_range(0, 3);
            n = (lc == 1) ? 7 : (lc == 2) ? 12 : 5;
            ha = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 3) : -1;
            halt_idle = $urandom_range(0, 5);
            do_instr(12'($urandom), 2'(lc), 1'($urandom),
                     ($urandom_range(0, 5) == 0) ? 7'd36 : 7'($urandom),
                     ha, -1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
